frame_diff_detect: RTL and testbench
====================================

# frame_diff_detect

Consumer of the packed 16-bit pixel stream {current gray, previous-frame gray} that the gray-packing stage writes to SDRAM and the SDRAM reader returns. Unpacks each word, computes the absolute inter-frame difference, and thresholds it to a binary motion pixel. Also accumulates a per-frame motion pixel count and a bounding box, and latches a frame-level motion verdict at frame end for the overlay and alarm logic.

## Interface
Parameters:
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- XW, 10, x coordinate width
- YW, 9, y coordinate width
- CNT_W, 19, motion pixel counter width
- MOVE_MIN, 100, minimum motion pixel count for the frame to be flagged as motion

Ports:
- clk  in  1  pixel clock
- resetb  in  1  asynchronous, active-low reset
- clken  in  1  pixel qualifier
- ivsync  in  1  high during the active frame
- ihsync  in  1  high during the active line
- igray  in  16  [15:8] current gray, [7:0] previous-frame gray
- iprev_ok  in  1  previous frame valid in SDRAM (driven by the SDRAM-write-stop flag)
- ithresh  in  8  difference threshold, sampled every cycle
- oe  out  1  output pixel valid
- ovsync, ohsync  out  1  syncs delayed to align with obin
- obin  out  1  motion pixel
- odiff  out  8  |cur − prev|, aligned with obin
- oframe_done  out  1  one-cycle pulse when frame results update
- omove  out  1  frame motion verdict
- ocount  out  CNT_W  motion pixels in the last frame
- ox_min, ox_max  out  XW  bounding box x
- oy_min, oy_max  out  YW  bounding box y

## Operation
- Input qualifier: v0 = clken & ivsync & ihsync.
- Stage 1 (registered): cur = igray[15:8], prev = igray[7:0]. d = |cur − prev| computed unsigned with 9-bit intermediate. d is forced to 0 when iprev_ok = 0. Registers v1 = v0.
- Stage 2 (registered): obin = v1 & (d1 > ithresh), with ithresh taken from the stage-1 register. odiff = d1. oe = v1.
- Coordinates, tracked at stage 2:
  - x increments on each oe and clears on the ohsync falling edge.
  - y increments on the ohsync falling edge only if at least one oe occurred in that line. y clears on the ovsync rising edge.
  - Both saturate at IMG_W−1 and IMG_H−1.
- Accumulators:
  - On obin: count increments, saturating at all-ones.
  - On obin: xmin = min(xmin, x), xmax = max(xmax, x), and likewise for y.
  - Initial values: xmin = IMG_W−1, ymin = IMG_H−1, xmax = 0, ymax = 0, count = 0.
- FSM states: IDLE, ACTIVE, LATCH.
  - IDLE → ACTIVE on the ovsync rising edge; accumulators initialise.
  - ACTIVE → LATCH on the ovsync falling edge.
  - LATCH → IDLE unconditionally after one cycle. In LATCH:
    - ocount = count and omove = (count ≥ MOVE_MIN).
    - Box outputs = accumulators if count ≠ 0, otherwise all 0.
    - oframe_done = 1.
  - An ovsync falling edge seen in IDLE, such as a partial frame after reset, produces no latch and no pulse.
- Reset mid-operation: FSM returns to IDLE and all accumulators initialise. Every output is 0.

## Timing
- Pixel latency: 2 cycles, igray → obin/odiff/oe. ovsync and ohsync are delayed by exactly 2 cycles.
- Reset values: every output is 0.
- oframe_done asserts in the cycle after the cycle in which the ovsync falling edge is detected, i.e. 3 cycles after the ivsync falling edge. The last pixel of the frame is always included.
- Frame result outputs change only in LATCH and hold until the next LATCH.
- A motion pixel arriving in the same cycle as the ovsync falling edge cannot occur (oe = 0 by construction). A pixel on the ovsync rising-edge cycle cannot occur either.
- ithresh changes take effect within 2 cycles. Mid-frame changes are allowed and are not retimed.

## Structure
- Shared package `md_pkg`:
  - IMG_W, IMG_H, XW, YW, CNT_W defaults.
  - FSM state typedef {IDLE, ACTIVE, LATCH}.
- One sub-module, `motion_bbox_acc`:
  - Holds the coordinate counters, accumulators, FSM and latch.
  - Inputs: oe, obin, ovsync, ohsync.
  - The top level holds the 2-stage difference pipeline.

## Test plan
- Reset/idle: hold resetb low, then release with no input activity → every output is 0 and oframe_done never pulses.
- Static scene: frame of 640×480, igray = 16'h8080, ithresh = 10, iprev_ok = 1 → obin always 0. At frame end: oframe_done pulse, ocount = 0, omove = 0, box = 0.
- Single block:
  - Stimulus: cur = 0xC0 and prev = 0x40 on x 100..109, y 50..59; elsewhere cur = prev; ithresh = 20.
  - Response: ocount = 100, omove = 1, ox_min = 100, ox_max = 109, oy_min = 50, oy_max = 59.
- Threshold edge: d = 20 with ithresh = 20 → obin = 0. d = 21 → obin = 1. Swapped order (cur < prev) gives the same result.
- First frame: iprev_ok = 0 with large differences → ocount = 0 and omove = 0. The next frame with iprev_ok = 1 detects motion.
- Reset mid-frame: assert resetb at line 200, release, and ivsync falls without a new rising edge → no oframe_done. The following full frame reports correct results.

Source files
------------

// File: rtl/md_pkg.sv
// Shared defaults and FSM state type for frame_diff_detect.
// Imported by the difference pipeline and the bbox accumulator.
package md_pkg;

  localparam int DEF_IMG_W    = 640;
  localparam int DEF_IMG_H    = 480;
  localparam int DEF_XW       = 10;
  localparam int DEF_YW       = 9;
  localparam int DEF_CNT_W    = 19;
  localparam int DEF_MOVE_MIN = 100;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    LATCH
  } state_t;

endpackage

// File: rtl/frame_diff_detect_if.sv
// Packed pixel stream from the SDRAM reader: clken, syncs, igray.
// master drives the stream, slave (frame_diff_detect) consumes it.
interface frame_diff_detect_if;

  logic        clken;
  logic        ivsync;
  logic        ihsync;
  logic [15:0] igray;

  modport master (
    output clken,
    output ivsync,
    output ihsync,
    output igray
  );

  modport slave (
    input clken,
    input ivsync,
    input ihsync,
    input igray
  );

endinterface

// File: rtl/motion_bbox_acc.sv
// Per-frame motion count, bounding box and verdict latch.
// In: oe/obin/ovsync/ohsync (stage 2). Out: frame results.
module motion_bbox_acc
  import md_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MOVE_MIN = DEF_MOVE_MIN
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             oe,
  input  logic             obin,
  input  logic             ovsync,
  input  logic             ohsync,
  output logic             oframe_done,
  output logic             omove,
  output logic [CNT_W-1:0] ocount,
  output logic [XW-1:0]    ox_min,
  output logic [XW-1:0]    ox_max,
  output logic [YW-1:0]    oy_min,
  output logic [YW-1:0]    oy_max
);

  localparam logic [XW-1:0] X_LAST =
    XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST =
    YW'(IMG_H - 1);
  localparam logic [CNT_W-1:0] C_MIN =
    CNT_W'(MOVE_MIN);

  state_t           state;
  logic             vs_q;
  logic             hs_q;
  logic             armed;
  logic             line_oe;
  logic [1:0]       warm;
  logic [XW-1:0]    x;
  logic [XW-1:0]    xmin;
  logic [XW-1:0]    xmax;
  logic [YW-1:0]    y;
  logic [YW-1:0]    ymin;
  logic [YW-1:0]    ymax;
  logic [CNT_W-1:0] cnt;
  logic             vrise;
  logic             vfall;
  logic             hfall;

  // A frame may only start after ovsync has been seen low
  // once the 2-stage pipeline has refilled after reset, so a
  // frame already in flight at reset release is ignored.
  assign vrise = armed & ovsync & ~vs_q;
  assign vfall = vs_q & ~ovsync;
  assign hfall = hs_q & ~ohsync;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      warm  <= 2'd0;
      armed <= 1'b0;
    end else begin
      vs_q <= ovsync;
      hs_q <= ohsync;
      if (warm != 2'd2)
        warm <= warm + 2'd1;
      if (warm == 2'd2 && !ovsync)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      x       <= '0;
      y       <= '0;
      line_oe <= 1'b0;
    end else begin
      if (hfall) begin
        x       <= '0;
        line_oe <= 1'b0;
        if (line_oe && y != Y_LAST)
          y <= y + YW'(1);
      end else if (oe) begin
        line_oe <= 1'b1;
        if (x != X_LAST)
          x <= x + XW'(1);
      end
      if (vrise)
        y <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      cnt         <= '0;
      xmin        <= X_LAST;
      xmax        <= '0;
      ymin        <= Y_LAST;
      ymax        <= '0;
      oframe_done <= 1'b0;
      omove       <= 1'b0;
      ocount      <= '0;
      ox_min      <= '0;
      ox_max      <= '0;
      oy_min      <= '0;
      oy_max      <= '0;
    end else begin
      oframe_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vrise) begin
            state <= ACTIVE;
            cnt   <= '0;
            xmin  <= X_LAST;
            xmax  <= '0;
            ymin  <= Y_LAST;
            ymax  <= '0;
          end
        end
        ACTIVE: begin
          if (obin) begin
            if (cnt != '1)
              cnt <= cnt + CNT_W'(1);
            if (x < xmin) xmin <= x;
            if (x > xmax) xmax <= x;
            if (y < ymin) ymin <= y;
            if (y > ymax) ymax <= y;
          end
          if (vfall) begin
            state       <= LATCH;
            oframe_done <= 1'b1;
            ocount      <= cnt;
            omove       <= (cnt >= C_MIN);
            ox_min <= (cnt != '0) ? xmin : '0;
            ox_max <= (cnt != '0) ? xmax : '0;
            oy_min <= (cnt != '0) ? ymin : '0;
            oy_max <= (cnt != '0) ? ymax : '0;
          end
        end
        LATCH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/frame_diff_detect.sv
// Inter-frame |cur-prev| threshold with per-frame motion stats.
// Ports: pix stream (slave), iprev_ok, ithresh, pixel + frame outs.
module frame_diff_detect
  import md_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MOVE_MIN = DEF_MOVE_MIN
) (
  input  logic               clk,
  input  logic               resetb,
  frame_diff_detect_if.slave pix,
  input  logic               iprev_ok,
  input  logic [7:0]         ithresh,
  output logic               oe,
  output logic               ovsync,
  output logic               ohsync,
  output logic               obin,
  output logic [7:0]         odiff,
  output logic               oframe_done,
  output logic               omove,
  output logic [CNT_W-1:0]   ocount,
  output logic [XW-1:0]      ox_min,
  output logic [XW-1:0]      ox_max,
  output logic [YW-1:0]      oy_min,
  output logic [YW-1:0]      oy_max
);

  logic       v0;
  logic       v1;
  logic       vs1;
  logic       hs1;
  logic [7:0] d1;
  logic [7:0] th1;
  logic [8:0] sub;
  logic [7:0] ad;

  assign v0  = pix.clken & pix.ivsync & pix.ihsync;
  assign sub = {1'b0, pix.igray[15:8]}
             - {1'b0, pix.igray[7:0]};
  // Borrow in bit 8 means cur < prev: negate the low byte.
  assign ad  = sub[8] ? (~sub[7:0] + 8'd1)
                      : sub[7:0];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      v1  <= 1'b0;
      vs1 <= 1'b0;
      hs1 <= 1'b0;
      d1  <= '0;
      th1 <= '0;
    end else begin
      v1  <= v0;
      vs1 <= pix.ivsync;
      hs1 <= pix.ihsync;
      d1  <= iprev_ok ? ad : 8'd0;
      th1 <= ithresh;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      oe     <= 1'b0;
      obin   <= 1'b0;
      odiff  <= '0;
      ovsync <= 1'b0;
      ohsync <= 1'b0;
    end else begin
      oe     <= v1;
      obin   <= v1 & (d1 > th1);
      odiff  <= d1;
      ovsync <= vs1;
      ohsync <= hs1;
    end
  end

  motion_bbox_acc #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .XW       (XW),
    .YW       (YW),
    .CNT_W    (CNT_W),
    .MOVE_MIN (MOVE_MIN)
  ) u_acc (
    .clk         (clk),
    .resetb      (resetb),
    .oe          (oe),
    .obin        (obin),
    .ovsync      (ovsync),
    .ohsync      (ohsync),
    .oframe_done (oframe_done),
    .omove       (omove),
    .ocount      (ocount),
    .ox_min      (ox_min),
    .ox_max      (ox_max),
    .oy_min      (oy_min),
    .oy_max      (oy_max)
  );

endmodule

// File: tb/tb_frame_diff_detect.sv
// Randomized bench for frame_diff_detect on a reduced 128x64 frame.
// Per-pixel queue model plus per-frame count/box/verdict model.
module tb_frame_diff_detect;

  localparam int W  = 128;
  localparam int H  = 64;
  localparam int CW = 19;

  logic          clk = 1'b0;
  logic          resetb;
  logic          iprev_ok;
  logic [7:0]    ithresh;
  logic          oe;
  logic          ovsync;
  logic          ohsync;
  logic          obin;
  logic [7:0]    odiff;
  logic          oframe_done;
  logic          omove;
  logic [CW-1:0] ocount;
  logic [9:0]    ox_min;
  logic [9:0]    ox_max;
  logic [8:0]    oy_min;
  logic [8:0]    oy_max;

  int n_chk    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct packed {
    logic       bin;
    logic [7:0] diff;
  } px_t;

  px_t exp_q[$];

  always #5 clk = ~clk;

  frame_diff_detect_if pix ();

  frame_diff_detect #(
    .IMG_W    (W),
    .IMG_H    (H),
    .XW       (10),
    .YW       (9),
    .CNT_W    (CW),
    .MOVE_MIN (100)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .pix         (pix),
    .iprev_ok    (iprev_ok),
    .ithresh     (ithresh),
    .oe          (oe),
    .ovsync      (ovsync),
    .ohsync      (ohsync),
    .obin        (obin),
    .odiff       (odiff),
    .oframe_done (oframe_done),
    .omove       (omove),
    .ocount      (ocount),
    .ox_min      (ox_min),
    .ox_max      (ox_max),
    .oy_min      (oy_min),
    .oy_max      (oy_max)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    px_t e;
    if (resetb === 1'b1 && oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_px", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("obin", obin, e.bin);
        check("odiff", odiff, e.diff);
        check("sync_al", {ovsync, ohsync}, 2'b11);
      end
    end
    if (oframe_done === 1'b1)
      done_cnt++;
  end

  task automatic drive_frame(
    input int nl, input int w, input int th,
    input bit pok, input int mode,
    input int bx0, input int bx1,
    input int by0, input int by1,
    input int rst_line
  );
    int cnt, xmn, xmx, ymn, ymx;
    int xx, yy, d, lat, i, dc0;
    logic [7:0] c, p;
    px_t e;
    cnt = 0;
    xmn = W - 1;
    ymn = H - 1;
    xmx = 0;
    ymx = 0;
    lat = 0;
    ithresh  = 8'(th);
    iprev_ok = pok;
    pix.ivsync = 1'b1;
    pix.ihsync = 1'b0;
    pix.clken  = 1'b1;
    repeat (3) step();
    for (int l = 0; l < nl; l++) begin
      if (l == rst_line) begin
        resetb = 1'b0;
        repeat (3) step();
        check("rst_mid_out",
              {oframe_done, omove, ocount, oe}, 0);
        resetb = 1'b1;
        repeat (2) step();
      end
      pix.ihsync = 1'b1;
      i = 0;
      while (i < w) begin
        pix.clken = (mode == 2)
                  ? ($urandom_range(0, 7) != 0) : 1'b1;
        case (mode)
          0: begin
            c = 8'h80;
            p = 8'h80;
          end
          1: begin
            if (i >= bx0 && i <= bx1 &&
                l >= by0 && l <= by1) begin
              c = 8'hC0;
              p = 8'h40;
            end else begin
              c = 8'($urandom);
              p = c;
            end
          end
          3: begin
            case ((i + l) % 6)
              0: begin c = 8'd60;  p = 8'd40;  end
              1: begin c = 8'd61;  p = 8'd40;  end
              2: begin c = 8'd40;  p = 8'd60;  end
              3: begin c = 8'd40;  p = 8'd61;  end
              4: begin c = 8'd255; p = 8'd0;   end
              default: begin c = 8'd0; p = 8'd255; end
            endcase
          end
          default: begin
            c = 8'($urandom);
            p = 8'($urandom);
          end
        endcase
        pix.igray = {c, p};
        if (pix.clken) begin
          if (!pok)     d = 0;
          else if (c > p) d = int'(c) - int'(p);
          else          d = int'(p) - int'(c);
          e.bin  = (d > th);
          e.diff = 8'(d);
          exp_q.push_back(e);
          if (d > th) begin
            xx = (i < W) ? i : W - 1;
            yy = (l < H) ? l : H - 1;
            cnt++;
            if (xx < xmn) xmn = xx;
            if (xx > xmx) xmx = xx;
            if (yy < ymn) ymn = yy;
            if (yy > ymx) ymx = yy;
          end
          i++;
        end
        step();
      end
      pix.ihsync = 1'b0;
      pix.clken  = 1'b0;
      repeat (4) step();
    end
    repeat (2) step();
    dc0 = done_cnt;
    pix.ivsync = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (oframe_done === 1'b1 && lat == 0)
        lat = n;
    end
    if (rst_line >= 0) begin
      check("nodone_lat", lat, 0);
      check("nodone_cnt", done_cnt - dc0, 0);
    end else begin
      exp_done++;
      check("done_lat", lat, 3);
      check("done_cnt", done_cnt - dc0, 1);
      check("ocount", ocount, cnt);
      check("omove", omove, cnt >= 100);
      check("ox_min", ox_min, cnt ? xmn : 0);
      check("ox_max", ox_max, cnt ? xmx : 0);
      check("oy_min", oy_min, cnt ? ymn : 0);
      check("oy_max", oy_max, cnt ? ymx : 0);
    end
    repeat (6) step();
  endtask

  initial begin
    resetb     = 1'b0;
    pix.clken  = 1'b0;
    pix.ivsync = 1'b0;
    pix.ihsync = 1'b0;
    pix.igray  = '0;
    iprev_ok   = 1'b0;
    ithresh    = '0;
    repeat (4) step();
    check("rst_pix",
          {oe, ovsync, ohsync, obin, odiff}, 0);
    check("rst_frm", {oframe_done, omove, ocount}, 0);
    check("rst_bx", {ox_min, ox_max}, 0);
    check("rst_by", {oy_min, oy_max}, 0);
    resetb = 1'b1;
    repeat (20) step();
    check("idle_pix",
          {oe, ovsync, ohsync, obin, odiff}, 0);
    check("idle_frm", {omove, ocount}, 0);
    check("idle_box",
          {ox_min, ox_max, oy_min, oy_max}, 0);
    check("idle_done", done_cnt, 0);

    // static scene
    drive_frame(20, W, 10, 1'b1, 0, 0, 0, 0, 0, -1);
    // 10x10 block: count 100, verdict set
    drive_frame(60, 112, 20, 1'b1, 1,
                100, 109, 50, 59, -1);
    // 9x11 block: count 99, just under verdict
    drive_frame(20, 32, 20, 1'b1, 1,
                10, 18, 5, 15, -1);
    // threshold edges, both subtraction orders
    drive_frame(8, 24, 20, 1'b1, 3, 0, 0, 0, 0, -1);
    // first frame without valid previous frame
    drive_frame(16, 64, 20, 1'b0, 2, 0, 0, 0, 0, -1);
    drive_frame(16, 64, $urandom_range(0, 80),
                1'b1, 2, 0, 0, 0, 0, -1);
    // over-wide, over-tall frame: x/y saturate
    drive_frame(H + 2, W + 3, $urandom_range(100, 200),
                1'b1, 2, 0, 0, 0, 0, -1);
    // reset mid-frame, then a full frame
    drive_frame(40, 64, 30, 1'b1, 2, 0, 0, 0, 0, 20);
    drive_frame(60, 112, 20, 1'b1, 1,
                100, 109, 50, 59, -1);

    check("done_total", done_cnt, exp_done);
    check("q_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
